// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator for a synchronous instruction memory. It issues word
// addresses from the PC, presents returned words to decode over valid/ready,
// holds one stalled word in a skid register, and squashes on redirect.
module instruction_fetch_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] Read_Address,
   input  logic [DATA_WIDTH-1:0] Instruction,
   input  logic                  enable,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic                  fetch_valid,
   input  logic                  fetch_ready,
   output logic [DATA_WIDTH-1:0] fetch_instruction,
   output logic [ADDR_WIDTH-1:0] fetch_pc
);

   typedef enum logic [1:0] {EMPTY, PENDING, SKID} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pend_pc;
   logic [ADDR_WIDTH-1:0] skid_pc;
   logic [DATA_WIDTH-1:0] skid_instr;
   logic                  issue;

   assign Read_Address = pc;

   // A new read may go out only when the slot is free or being drained this cycle.
   assign issue = enable & ~redirect_valid & (~fetch_valid | fetch_ready);

   // State register; reset discards anything in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection; a redirect always returns to EMPTY.
   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = EMPTY;
      end else begin
         unique case (state)
            EMPTY:   state_nxt = issue ? PENDING : EMPTY;
            PENDING: state_nxt = fetch_ready ? (issue ? PENDING : EMPTY) : SKID;
            SKID:    state_nxt = fetch_ready ? (issue ? PENDING : EMPTY) : SKID;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Decode-side outputs; PENDING forwards the memory word straight through.
   always_comb begin
      fetch_valid       = 1'b0;
      fetch_instruction = '0;
      fetch_pc          = '0;
      unique case (state)
         PENDING: begin
            fetch_valid       = 1'b1;
            fetch_instruction = Instruction;
            fetch_pc          = pend_pc;
         end
         SKID: begin
            fetch_valid       = 1'b1;
            fetch_instruction = skid_instr;
            fetch_pc          = skid_pc;
         end
         default: ;
      endcase
      if (redirect_valid) begin
         fetch_valid = 1'b0;
      end
   end

   // PC advance and tag of the read currently in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc      <= '0;
         pend_pc <= '0;
      end else if (redirect_valid) begin
         pc <= redirect_target;
      end else if (issue) begin
         pc      <= pc + 1'b1;
         pend_pc <= pc;
      end
   end

   // Capture the memory word when decode stalls, since the memory output will change.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (state == PENDING && !fetch_ready && !redirect_valid) begin
         skid_instr <= Instruction;
         skid_pc    <= pend_pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a directed vector table, an async reset
// sequence, then randomized traffic against a single-slot transaction model.
module tb_instruction_fetch_unit;

   logic        clock;
   logic        reset;
   logic [3:0]  Read_Address;
   logic [31:0] Instruction;
   logic        enable;
   logic        redirect_valid;
   logic [3:0]  redirect_target;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_instruction;
   logic [3:0]  fetch_pc;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       en;
      logic       rv;
      logic [3:0] tgt;
      logic       rdy;
      logic [3:0] exp_ra;
      logic       exp_fv;
      logic [3:0] exp_pc;
      logic       chk_data;
   } vec_t;

   vec_t vecs[$];

   // Reference model: one delivery slot plus the next address to issue.
   logic       held_v;
   logic [3:0] held_pc;
   logic [3:0] pc_m;

   instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
      .clock             (clock),
      .reset             (reset),
      .Read_Address      (Read_Address),
      .Instruction       (Instruction),
      .enable            (enable),
      .redirect_valid    (redirect_valid),
      .redirect_target   (redirect_target),
      .fetch_valid       (fetch_valid),
      .fetch_ready       (fetch_ready),
      .fetch_instruction (fetch_instruction),
      .fetch_pc          (fetch_pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [3:0] a);
      return 32'hDEAD_0000 | 32'(a);
   endfunction

   // Synchronous memory: data for the address seen at the edge appears after it.
   always @(posedge clock) Instruction <= mem_word(Read_Address);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic en, input logic rv, input logic [3:0] tgt, input logic rdy,
                      input logic [3:0] exp_ra, input logic exp_fv, input logic [3:0] exp_pc,
                      input logic chk_data);
      vec_t v;
      v.en = en; v.rv = rv; v.tgt = tgt; v.rdy = rdy;
      v.exp_ra = exp_ra; v.exp_fv = exp_fv; v.exp_pc = exp_pc; v.chk_data = chk_data;
      vecs.push_back(v);
   endtask

   // Called at a negedge: drive, compare settled outputs, advance one clock.
   task automatic apply(input logic en, input logic rv, input logic [3:0] tgt, input logic rdy,
                        input logic [3:0] exp_ra, input logic exp_fv, input logic [3:0] exp_pc,
                        input logic chk_data);
      logic [31:0] exp_instr;
      enable          = en;
      redirect_valid  = rv;
      redirect_target = tgt;
      fetch_ready     = rdy;
      #1;
      exp_instr = exp_fv ? mem_word(exp_pc) : 32'h0;
      check("read_address", 32'(Read_Address), 32'(exp_ra));
      check("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
      if (chk_data) begin
         check("fetch_pc", 32'(fetch_pc), 32'(exp_pc));
         check("fetch_instruction", fetch_instruction, exp_instr);
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic mstep(input logic en, input logic rv, input logic [3:0] tgt, input logic rdy);
      logic fv_e;
      logic issue_e;
      fv_e    = held_v & ~rv;
      issue_e = en & ~rv & (~fv_e | rdy);
      apply(en, rv, tgt, rdy, pc_m, fv_e, fv_e ? held_pc : 4'd0, ~rv);
      if (rv) begin
         held_v = 1'b0;
         pc_m   = tgt;
      end else begin
         if (fv_e && rdy) held_v = 1'b0;
         if (issue_e) begin
            held_v  = 1'b1;
            held_pc = pc_m;
            pc_m    = pc_m + 4'd1;
         end
      end
   endtask

   initial begin
      reset           = 1'b1;
      enable          = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 4'd0;
      fetch_ready     = 1'b0;

      // Streaming from reset, including the 15 -> 0 wrap.
      for (int r = 0; r < 20; r++)
         add(1, 0, 0, 1, 4'(r), r > 0, (r > 0) ? 4'(r - 1) : 4'd0, 1);
      // Decode stalls for three cycles on pc 3, then the stream continues.
      add(1, 0, 0, 0, 4, 1, 3, 1);
      add(1, 0, 0, 0, 4, 1, 3, 1);
      add(1, 0, 0, 0, 4, 1, 3, 1);
      add(1, 0, 0, 1, 4, 1, 3, 1);
      add(1, 0, 0, 1, 5, 1, 4, 1);
      // Redirect to 9 while pc 5 is pending.
      add(1, 1, 9, 1, 6, 0, 0, 0);
      add(1, 0, 0, 1, 9, 0, 0, 1);
      add(1, 0, 0, 1, 10, 1, 9, 1);
      // Stall into the skid, then redirect to 2 from there.
      add(1, 0, 0, 0, 11, 1, 10, 1);
      add(1, 0, 0, 0, 11, 1, 10, 1);
      add(1, 1, 2, 1, 11, 0, 0, 0);
      add(1, 0, 0, 1, 2, 0, 0, 1);
      add(1, 0, 0, 1, 3, 1, 2, 1);
      add(1, 0, 0, 1, 4, 1, 3, 1);
      // enable low while pc 4 is pending: it drains, then nothing new.
      add(0, 0, 0, 1, 5, 1, 4, 1);
      add(0, 0, 0, 1, 5, 0, 0, 1);
      add(0, 0, 0, 1, 5, 0, 0, 1);
      add(1, 0, 0, 1, 5, 0, 0, 1);
      add(1, 0, 0, 1, 6, 1, 5, 1);

      repeat (2) @(negedge clock);
      check("reset_fetch_valid", 32'(fetch_valid), 32'h0);
      check("reset_read_address", 32'(Read_Address), 32'h0);
      reset = 1'b0;

      foreach (vecs[i])
         apply(vecs[i].en, vecs[i].rv, vecs[i].tgt, vecs[i].rdy,
               vecs[i].exp_ra, vecs[i].exp_fv, vecs[i].exp_pc, vecs[i].chk_data);

      // Async reset between edges while pc 6 is pending and pc 7 is on the bus.
      enable      = 1'b1;
      fetch_ready = 1'b1;
      #2;
      check("pre_reset_fetch_valid", 32'(fetch_valid), 32'h1);
      reset = 1'b1;
      #1;
      check("async_reset_fetch_valid", 32'(fetch_valid), 32'h0);
      check("async_reset_read_address", 32'(Read_Address), 32'h0);
      @(posedge clock);
      @(negedge clock);
      reset   = 1'b0;
      held_v  = 1'b0;
      held_pc = 4'd0;
      pc_m    = 4'd0;
      repeat (4) mstep(1'b1, 1'b0, 4'd0, 1'b1);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         logic       en;
         logic       rv;
         logic       rdy;
         logic [3:0] tgt;
         en  = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         tgt = 4'($urandom_range(0, 15));
         mstep(en, rv, tgt, rdy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
